// File: rtl/seg7_pkg.sv
// Shared segment encodings, the BCD-to-segment decoder and the conversion FSM state type
// for the countdown display driver.
package seg7_pkg;

    // Active-low segments, bit order {a,b,c,d,e,f,g} with a as the MSB
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } conv_state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per cycle, then a single-cycle
// done pulse while the packed BCD result is stable.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int BIN_W  = 6,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e          state;
    conv_state_e          state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [BIN_W-1:0]     sh;
    logic [4*DIGITS-1:0]  bcd_adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_SHIFT) cnt <= cnt + 1'b1;
            else                   cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load) state_nxt = ST_SHIFT;
            ST_SHIFT:  if (cnt == CNT_W'(BIN_W - 1)) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Nibbles that would reach 10 or more after the shift are corrected beforehand
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && load) begin
            sh  <= bin_in;
            bcd <= '0;
        end else if (state == ST_SHIFT) begin
            sh  <= sh << 1;
            bcd <= {bcd_adj[4*DIGITS-2:0], sh[BIN_W-1]};
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_COMMIT);

endmodule

// File: rtl/seg7_scan_driver.sv
// Binary-to-7-segment driver with parallel and anode-scanned outputs plus overflow flag.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero one.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 6,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  ovf,
    output logic [7*DIGITS-1:0]   seg_all,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int              IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int              SCNT_W    = $clog2(SCAN_DIV);
    localparam logic [BIN_W:0]  OVF_LIMIT = (BIN_W + 1)'(10 ** DIGITS);

    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [BIN_W-1:0]      bin_cap;
    logic                  cap_ovf;
    logic [7*DIGITS-1:0]   seg_commit;
    logic [3:0]            digit;
    logic                  seen;
    logic [SCNT_W-1:0]     scnt;
    logic [IDX_W-1:0]      idx;

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .bin_in (bin_in),
        .load   (load),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    // Range check uses the unshifted captured value, not the converter's truncated BCD
    always_ff @(posedge clk) begin
        if (load && !busy) bin_cap <= bin_in;
    end

    assign cap_ovf = ({1'b0, bin_cap} >= OVF_LIMIT);

    always_comb begin
        seg_commit = {DIGITS{SEG_BLANK}};
        seen       = 1'b0;
        digit      = '0;
        if (!cap_ovf) begin
            for (int i = DIGITS - 1; i >= 0; i--) begin
                digit = bcd[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
                if (digit != 4'd0 || i == 0) seen = 1'b1;
`else
                seen = 1'b1;
`endif
                seg_commit[7*i +: 7] = seen ? bcd_to_seg(digit) : SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_all <= {DIGITS{SEG_BLANK}};
            ovf     <= 1'b0;
        end else if (done) begin
            seg_all <= seg_commit;
            ovf     <= cap_ovf;
        end
    end

    // Free-running scan, independent of the conversion FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt  <= '0;
            idx   <= '0;
            seg_n <= SEG_BLANK;
            an_n  <= ~DIGITS'(1);
        end else begin
            if (scnt == SCNT_W'(SCAN_DIV - 1)) begin
                scnt <= '0;
                idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scnt <= scnt + 1'b1;
            end
            seg_n <= seg_all[7*idx +: 7];
            an_n  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 6-bit and a 7-bit instance (two digits, scan period 4)
// driven from a vector table, a scoreboard queue and hand-written corner sequences.
module tb_seg7_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TENS0 = 7'b1111111;
`else
    localparam logic [6:0] TENS0 = 7'b0000001;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  bin6 = '0;
    logic [6:0]  bin7 = '0;
    logic        load6 = 1'b0;
    logic        load7 = 1'b0;
    logic        busy6, busy7, ovf6, ovf7;
    logic [13:0] seg_all6, seg_all7;
    logic [6:0]  seg_n6, seg_n7;
    logic [1:0]  an_n6, an_n7;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        sel7;
        logic [6:0]  bin;
        logic [13:0] seg;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [13:0] seg;
        logic        ovf;
    } exp_t;

    vec_t vecs [11];
    exp_t sb [$];

    always #5 clk = ~clk;

    seg7_scan_driver #(.BIN_W(6), .DIGITS(2), .SCAN_DIV(4)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin6), .load(load6),
        .busy(busy6), .ovf(ovf6), .seg_all(seg_all6), .seg_n(seg_n6), .an_n(an_n6)
    );

    seg7_scan_driver #(.BIN_W(7), .DIGITS(2), .SCAN_DIV(4)) u_dut7 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin7), .load(load7),
        .busy(busy7), .ovf(ovf7), .seg_all(seg_all7), .seg_n(seg_n7), .an_n(an_n7)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic run_conv(input logic sel7, input logic [6:0] b, input logic [13:0] es,
                            input logic eo, input string nm);
        logic [13:0] prev;
        logic        hold_bad;
        int          n;
        exp_t        e;
        @(negedge clk);
        prev = sel7 ? seg_all7 : seg_all6;
        if (sel7) begin load7 = 1'b1; bin7 = b; end
        else      begin load6 = 1'b1; bin6 = b[5:0]; end
        sb.push_back('{es, eo});
        @(negedge clk);
        load6 = 1'b0;
        load7 = 1'b0;
        n = 0;
        hold_bad = 1'b0;
        while ((sel7 ? busy7 : busy6) && n < 50) begin
            n++;
            if ((sel7 ? seg_all7 : seg_all6) !== prev) hold_bad = 1'b1;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, n, sel7 ? 8 : 7);
        check({nm, " hold_during_busy"}, {31'd0, hold_bad}, 0);
        if (sb.size() == 0) begin
            check({nm, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({nm, " seg_all"}, {18'd0, (sel7 ? seg_all7 : seg_all6)}, {18'd0, e.seg});
            check({nm, " ovf"}, {31'd0, (sel7 ? ovf7 : ovf6)}, {31'd0, e.ovf});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev_an;
        int         run, changes, n;
        logic [13:0] keep;

        vecs[0]  = '{1'b0, 7'd42,  {7'b1001100, 7'b0010010}, 1'b0};
        vecs[1]  = '{1'b0, 7'd15,  {7'b1001111, 7'b0100100}, 1'b0};
        vecs[2]  = '{1'b0, 7'd59,  {7'b0100100, 7'b0000100}, 1'b0};
        vecs[3]  = '{1'b0, 7'd7,   {TENS0,      7'b0001111}, 1'b0};
        vecs[4]  = '{1'b0, 7'd0,   {TENS0,      7'b0000001}, 1'b0};
        vecs[5]  = '{1'b0, 7'd63,  {7'b0100000, 7'b0000110}, 1'b0};
        vecs[6]  = '{1'b1, 7'd100, 14'h3FFF,                 1'b1};
        vecs[7]  = '{1'b1, 7'd9,   {TENS0,      7'b0000100}, 1'b0};
        vecs[8]  = '{1'b1, 7'd99,  {7'b0000100, 7'b0000100}, 1'b0};
        vecs[9]  = '{1'b1, 7'd127, 14'h3FFF,                 1'b1};
        vecs[10] = '{1'b1, 7'd10,  {7'b1001111, 7'b0000001}, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst seg_all6", {18'd0, seg_all6}, 32'h3FFF);
        check("rst seg_n6", {25'd0, seg_n6}, 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel seg_all6", {18'd0, seg_all6}, 32'h3FFF);
        check("rel seg_all7", {18'd0, seg_all7}, 32'h3FFF);
        check("rel busy6", {31'd0, busy6}, 0);
        check("rel busy7", {31'd0, busy7}, 0);
        check("rel ovf6", {31'd0, ovf6}, 0);
        check("rel ovf7", {31'd0, ovf7}, 0);
        check("rel an_n6", {30'd0, an_n6}, 32'h2);
        check("rel seg_n6", {25'd0, seg_n6}, 32'h7F);

        for (int i = 0; i < 11; i++) begin
            run_conv(vecs[i].sel7, vecs[i].bin, vecs[i].seg, vecs[i].ovf,
                     $sformatf("vec%0d_%0d", i, vecs[i].bin));
        end

        // Scan with two distinct digits on display
        run_conv(1'b0, 7'd42, {7'b1001100, 7'b0010010}, 1'b0, "scan_setup_42");
        @(negedge clk);
        prev_an = an_n6;
        run = 1;
        changes = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (an_n6 != prev_an) begin
                if (changes > 0) check("scan period", run, 4);
                changes++;
                run = 1;
                prev_an = an_n6;
            end else begin
                run++;
            end
            check("scan an_n onehot", {31'd0, (an_n6 == 2'b10 || an_n6 == 2'b01)}, 1);
            check("scan seg_n slice", {25'd0, seg_n6},
                  {25'd0, (an_n6 == 2'b10) ? 7'b0010010 : 7'b1001100});
        end
        check("scan wraps", {31'd0, (changes >= 5)}, 1);

        // Loads while busy are ignored
        @(negedge clk);
        load6 = 1'b1;
        bin6 = 6'd15;
        sb.push_back('{{7'b1001111, 7'b0100100}, 1'b0});
        n = 0;
        for (int c = 1; c < 50; c++) begin
            @(negedge clk);
            load6 = (c == 2 || c == 4);
            bin6 = 6'd33;
            if (!busy6) break;
            n++;
        end
        load6 = 1'b0;
        check("ignored_load busy_cycles", n, 7);
        begin
            exp_t e;
            e = sb.pop_front();
            check("ignored_load seg_all", {18'd0, seg_all6}, {18'd0, e.seg});
        end
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy6) n++;
        end
        check("ignored_load no_restart", n, 0);
        check("ignored_load seg_kept", {18'd0, seg_all6}, {18'd0, 7'b1001111, 7'b0100100});

        // Reset in the third SHIFT cycle
        @(negedge clk);
        keep = seg_all6;
        load6 = 1'b1;
        bin6 = 6'd59;
        @(negedge clk);
        load6 = 1'b0;
        repeat (2) @(negedge clk);
        check("abort busy_before", {31'd0, busy6}, 1);
        check("abort seg_held", {18'd0, seg_all6}, {18'd0, keep});
        rst_n = 1'b0;
        #1;
        check("abort seg_all", {18'd0, seg_all6}, 32'h3FFF);
        check("abort busy", {31'd0, busy6}, 0);
        check("abort an_n", {30'd0, an_n6}, 32'h2);
        check("abort seg_n", {25'd0, seg_n6}, 32'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort no_commit seg_all", {18'd0, seg_all6}, 32'h3FFF);
        check("abort no_commit busy", {31'd0, busy6}, 0);
        check("abort no_commit ovf", {31'd0, ovf6}, 0);

        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
